// File: rtl/arbiter_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared definitions for dma_bus_arbiter:
//   arb_state_t      - bus ownership FSM states
//   DEF_MAX_BURST    - default maximum consecutive DMA reads per grant
//   DEF_HALT_LAT     - default cycles between halt_b falling and DMA handover
//   DEF_CPU_MIN      - default guaranteed CPU guard cycles after a DMA release
//   cnt_width()      - bit width needed to hold the value n (minimum 1)
// -----------------------------------------------------------------------------
package arbiter_pkg;

   typedef enum logic [2:0] {
      CPU_OWN   = 3'd0,
      HALT_WAIT = 3'd1,
      DMA_OWN   = 3'd2,
      RELEASE   = 3'd3,
      CPU_GUARD = 3'd4
   } arb_state_t;

   localparam int DEF_MAX_BURST = 64;
   localparam int DEF_HALT_LAT  = 1;
   localparam int DEF_CPU_MIN   = 4;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dma_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dma_bus_arbiter
// Shares one synchronous memory port between a CPU and a DMA read engine.
// The CPU is halted (halt_b low) before the DMA takes the bus, the DMA gets at
// most MAX_BURST reads per grant, and the CPU is then guaranteed a release
// cycle plus CPU_MIN guard cycles before the DMA can be considered again.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   cpu_addr, cpu_we       CPU address / write enable
//   cpu_din                read data returned to the CPU
//   halt_b                 active-low halt to the CPU
//   dma_req, dma_addr      DMA level request and read address
//   dma_grant              DMA owns the bus (one read) this cycle
//   dma_rvalid, dma_rdata  DMA read data, valid one cycle after a grant
//   mem_addr, mem_we       memory address / write enable
//   mem_rdata              memory read data (one cycle latency)
// -----------------------------------------------------------------------------
module dma_bus_arbiter
   import arbiter_pkg::*;
#(
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int HALT_LAT  = DEF_HALT_LAT,
   parameter int CPU_MIN   = DEF_CPU_MIN
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   output logic [7:0]  cpu_din,
   output logic        halt_b,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   output logic        dma_grant,
   output logic        dma_rvalid,
   output logic [7:0]  dma_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);

   localparam int BW = cnt_width(MAX_BURST);
   localparam int HW = cnt_width(HALT_LAT);
   localparam int GW = cnt_width(CPU_MIN);

   localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [HW-1:0] HALT_LAST  = HW'(HALT_LAT - 1);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(CPU_MIN);

   arb_state_t    state_reg, state_next;
   logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
   logic [HW-1:0] wait_cnt_reg, wait_cnt_next;
   logic [GW-1:0] guard_cnt_reg, guard_cnt_next;
   logic          rvalid_reg;
   logic          cpu_rd_prev_reg;   // previous cycle was a CPU-owned cycle
   logic [7:0]    cpu_din_reg;

   always_comb begin
      state_next     = state_reg;
      burst_cnt_next = burst_cnt_reg;
      wait_cnt_next  = wait_cnt_reg;
      guard_cnt_next = guard_cnt_reg;
      halt_b         = 1'b1;
      dma_grant      = 1'b0;
      mem_addr       = cpu_addr;
      mem_we         = cpu_we;

      case (state_reg)
         CPU_OWN: begin
            if (dma_req) begin
               state_next    = HALT_WAIT;
               wait_cnt_next = '0;
            end
         end

         // Bus stays with the CPU so a write issued as halt_b falls completes.
         HALT_WAIT: begin
            halt_b = 1'b0;
            if (wait_cnt_reg == HALT_LAST) begin
               state_next     = DMA_OWN;
               burst_cnt_next = '0;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end

         // A cycle with dma_req low performs no read and ends the grant.
         DMA_OWN: begin
            halt_b   = 1'b0;
            mem_addr = dma_addr;
            mem_we   = 1'b0;
            if (!dma_req) begin
               state_next = RELEASE;
            end else begin
               dma_grant = 1'b1;
               if (burst_cnt_reg != BURST_MAX) begin
                  burst_cnt_next = burst_cnt_reg + 1'b1;
               end
               if (burst_cnt_reg == BURST_LAST) begin
                  state_next = RELEASE;
               end
            end
         end

         // CPU resumes but cannot write during the handback cycle.
         RELEASE: begin
            mem_we         = 1'b0;
            state_next     = CPU_GUARD;
            guard_cnt_next = GUARD_LOAD;
         end

         // Like CPU_OWN but dma_req is ignored until the counter runs out.
         CPU_GUARD: begin
            if (guard_cnt_reg != '0) begin
               guard_cnt_next = guard_cnt_reg - 1'b1;
            end
            if (guard_cnt_reg <= GW'(1)) begin
               state_next = CPU_OWN;
            end
         end

         default: begin
            state_next = CPU_OWN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= CPU_OWN;
         burst_cnt_reg   <= '0;
         wait_cnt_reg    <= '0;
         guard_cnt_reg   <= '0;
         rvalid_reg      <= 1'b0;
         cpu_rd_prev_reg <= 1'b0;
         cpu_din_reg     <= 8'h00;
      end else begin
         state_reg       <= state_next;
         burst_cnt_reg   <= burst_cnt_next;
         wait_cnt_reg    <= wait_cnt_next;
         guard_cnt_reg   <= guard_cnt_next;
         rvalid_reg      <= dma_grant;
         // The CPU is running (and so owns any read) whenever halt_b is high.
         cpu_rd_prev_reg <= halt_b;
         if (cpu_rd_prev_reg) begin
            cpu_din_reg <= mem_rdata;
         end
      end
   end

   assign dma_rvalid = rvalid_reg;
   assign dma_rdata  = mem_rdata;
   assign cpu_din    = cpu_rd_prev_reg ? mem_rdata : cpu_din_reg;

endmodule
